// File: rtl/edge_delay_meter.sv
// Measures start->stop rising-edge delay in cycles; result one cycle after the stop edge,
// window stats one cycle later. No backpressure: pulses are one cycle, outputs hold.
module edge_delay_meter #(
  parameter int COUNTER_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOG2_AVERAGE   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [COUNTER_WIDTH-1:0] measurement,
  output logic                     measurement_valid,
  output logic                     timeout,
  output logic [COUNTER_WIDTH-1:0] average,
  output logic [COUNTER_WIDTH-1:0] minimum,
  output logic [COUNTER_WIDTH-1:0] maximum,
  output logic                     average_valid
);

  localparam int SUM_WIDTH = COUNTER_WIDTH + LOG2_AVERAGE;
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_VAL = COUNTER_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [LOG2_AVERAGE:0]    LAST_IDX    = (LOG2_AVERAGE+1)'((1 << LOG2_AVERAGE) - 1);

  typedef enum logic {IDLE, COUNTING} state_t;

  state_t                   state;
  logic                     start_d, stop_d;
  logic                     start_edge, stop_edge;
  logic [COUNTER_WIDTH-1:0] counter;
  logic [SUM_WIDTH-1:0]     sum;
  logic [SUM_WIDTH-1:0]     sum_next;
  logic [LOG2_AVERAGE:0]    count;
  logic [COUNTER_WIDTH-1:0] run_min, run_max;
  logic [COUNTER_WIDTH-1:0] min_next, max_next;
  logic                     last_sample;

  assign start_edge  = start & ~start_d;
  assign stop_edge   = stop & ~stop_d;

  // Window arithmetic folds in the sample being presented this cycle.
  assign sum_next    = sum + SUM_WIDTH'(measurement);
  assign min_next    = (measurement < run_min) ? measurement : run_min;
  assign max_next    = (measurement > run_max) ? measurement : run_max;
  assign last_sample = (count == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      // Loading the live inputs keeps a level held through reset from looking like an edge.
      start_d           <= start;
      stop_d            <= stop;
      state             <= IDLE;
      counter           <= '0;
      busy              <= 1'b0;
      measurement       <= '0;
      measurement_valid <= 1'b0;
      timeout           <= 1'b0;
      average           <= '0;
      minimum           <= '0;
      maximum           <= '0;
      average_valid     <= 1'b0;
      sum               <= '0;
      count             <= '0;
      run_min           <= '1;
      run_max           <= '0;
    end else begin
      start_d           <= start;
      stop_d            <= stop;
      measurement_valid <= 1'b0;
      timeout           <= 1'b0;
      average_valid     <= 1'b0;

      case (state)
        IDLE: begin
          if (start_edge && stop_edge) begin
            measurement       <= '0;
            measurement_valid <= 1'b1;
          end else if (start_edge) begin
            counter <= COUNTER_WIDTH'(1);
            busy    <= 1'b1;
            state   <= COUNTING;
          end
        end
        COUNTING: begin
          // A stop on the timeout edge still counts as a valid measurement.
          if (stop_edge) begin
            measurement       <= counter;
            measurement_valid <= 1'b1;
            busy              <= 1'b0;
            state             <= IDLE;
          end else if (counter == TIMEOUT_VAL) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter + COUNTER_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (measurement_valid) begin
        if (last_sample) begin
          average       <= COUNTER_WIDTH'(sum_next >> LOG2_AVERAGE);
          minimum       <= min_next;
          maximum       <= max_next;
          average_valid <= 1'b1;
          sum           <= '0;
          count         <= '0;
          run_min       <= '1;
          run_max       <= '0;
        end else begin
          sum     <= sum_next;
          count   <= count + (LOG2_AVERAGE+1)'(1);
          run_min <= min_next;
          run_max <= max_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_delay_meter.sv
// Scoreboarded directed bench for edge_delay_meter (8-bit, timeout 20, window of 4).
module tb_edge_delay_meter;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       busy;
  logic [7:0] measurement;
  logic       measurement_valid;
  logic       timeout;
  logic [7:0] average;
  logic [7:0] minimum;
  logic [7:0] maximum;
  logic       average_valid;

  typedef struct {
    int avg;
    int mn;
    int mx;
  } win_t;

  int   exp_meas[$];
  win_t exp_win[$];
  int   exp_to      = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   busy_cycles = 0;
  logic prev_mv     = 1'b0;

  edge_delay_meter #(
    .COUNTER_WIDTH (8),
    .TIMEOUT_CYCLES(20),
    .LOG2_AVERAGE  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .busy             (busy),
    .measurement      (measurement),
    .measurement_valid(measurement_valid),
    .timeout          (timeout),
    .average          (average),
    .minimum          (minimum),
    .maximum          (maximum),
    .average_valid    (average_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (busy) busy_cycles++;
      if (measurement_valid) begin
        check("meas_expected", int'(exp_meas.size() > 0), 1);
        if (exp_meas.size() > 0) check("measurement", int'(measurement), exp_meas.pop_front());
      end
      if (timeout) begin
        check("timeout_expected", int'(exp_to > 0), 1);
        check("busy_low_at_timeout", int'(busy), 0);
        if (exp_to > 0) exp_to--;
      end
      if (average_valid) begin
        check("avg_follows_valid", int'(prev_mv), 1);
        check("avg_expected", int'(exp_win.size() > 0), 1);
        if (exp_win.size() > 0) begin
          win_t w;
          w = exp_win.pop_front();
          check("average", int'(average), w.avg);
          check("minimum", int'(minimum), w.mn);
          check("maximum", int'(maximum), w.mx);
        end
      end
      prev_mv = measurement_valid;
    end else begin
      prev_mv = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Start edge is sampled at edge E, stop edge at E+d (d=0: same edge).
  task automatic measure(input int d);
    @(posedge clock); #1;
    start = 1'b1;
    if (d == 0) stop = 1'b1;
    else begin
      repeat (d) @(posedge clock);
      #1 stop = 1'b1;
    end
    @(posedge clock); #1;
    start = 1'b0;
    stop  = 1'b0;
    idle(3);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (exp_meas.size() + exp_win.size() + exp_to) > 0; i++)
      @(posedge clock);
    #1;
    check(name, exp_meas.size() + exp_win.size() + exp_to, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_measurement"}, int'(measurement), 0);
    check({tag, "_average"}, int'(average), 0);
    check({tag, "_minimum"}, int'(minimum), 0);
    check({tag, "_maximum"}, int'(maximum), 0);
    check({tag, "_pulses"}, int'({measurement_valid, timeout, average_valid}), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // Single measurement of 5 cycles.
    exp_meas.push_back(5);
    busy_cycles = 0;
    measure(5);
    drain("drain_single");
    check("busy_cycles_5", busy_cycles, 5);

    // Coincident start and stop edges.
    exp_meas.push_back(0);
    busy_cycles = 0;
    measure(0);
    drain("drain_coincident");
    check("busy_cycles_0", busy_cycles, 0);

    // Full window 3,5,6,10 then a fifth sample that must not disturb the window outputs.
    do_reset();
    foreach (exp_meas[i]) ;
    exp_meas.push_back(3);  measure(3);
    exp_meas.push_back(5);  measure(5);
    exp_meas.push_back(6);  measure(6);
    exp_meas.push_back(10);
    exp_win.push_back('{avg: 6, mn: 3, mx: 10});
    measure(10);
    exp_meas.push_back(7);  measure(7);
    drain("drain_window1");
    check("hold_average", int'(average), 6);
    check("hold_minimum", int'(minimum), 3);
    check("hold_maximum", int'(maximum), 10);

    // Timeout with a late stop that must be ignored.
    do_reset();
    exp_to = 1;
    @(posedge clock); #1 start = 1'b1;
    repeat (22) @(posedge clock);
    #1 stop = 1'b1;
    idle(1);
    start = 1'b0;
    stop  = 1'b0;
    idle(3);
    drain("drain_timeout");
    check("busy_after_timeout", int'(busy), 0);

    // Stop exactly at the limit, with a second start edge at +4 that must not restart.
    exp_meas.push_back(20);
    @(posedge clock); #1 start = 1'b1;
    repeat (2) @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 start = 1'b1;
    repeat (16) @(posedge clock);
    #1 stop = 1'b1;
    idle(1);
    start = 1'b0;
    stop  = 1'b0;
    idle(3);
    exp_meas.push_back(2);  measure(2);
    exp_meas.push_back(9);  measure(9);
    exp_meas.push_back(4);
    exp_win.push_back('{avg: 8, mn: 2, mx: 20});
    measure(4);
    drain("drain_window2");

    // Reset mid-measurement with start held high through and after reset.
    @(posedge clock); #1 start = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(2);
    check_all_zero("midreset");
    busy_cycles = 0;
    idle(10);
    check("held_start_no_busy", busy_cycles, 0);
    start = 1'b0;
    idle(1);
    exp_meas.push_back(3);
    measure(3);
    drain("drain_after_reset");

    check("final_meas_queue", exp_meas.size(), 0);
    check("final_win_queue", exp_win.size(), 0);
    check("final_timeouts", exp_to, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_delay_meter.md
# edge_delay_meter

Measures, in clock cycles, the delay between a rising edge launched into a delay path (start) and the rising edge returning from it (stop). It accumulates a window of 2^LOG2_AVERAGE measurements and reports the truncated mean, minimum and maximum. It sits at the output of the clocked/cable delay models in simulation benches, and on-chip at the return of a loopback path. It consumes the delayed copy those stages produce.

## Interface
- COUNTER_WIDTH, 16, width of measurement, average, minimum and maximum.
- TIMEOUT_CYCLES, 1000, maximum measurable delay. Must be < 2^COUNTER_WIDTH.
- LOG2_AVERAGE, 3, window size is 2^LOG2_AVERAGE valid measurements.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch signal. Synchronous to clock; no internal synchronizer.
- stop  in  1  returned (delayed) signal. Synchronous to clock.
- busy  out  1  high while a measurement is in progress.
- measurement  out  COUNTER_WIDTH  last single-shot delay; holds until the next valid.
- measurement_valid  out  1  one-cycle pulse.
- timeout  out  1  one-cycle pulse.
- average  out  COUNTER_WIDTH  truncated window mean; holds.
- minimum  out  COUNTER_WIDTH  window minimum; holds.
- maximum  out  COUNTER_WIDTH  window maximum; holds.
- average_valid  out  1  one-cycle pulse.

## Operation
- Edge detect: start_d and stop_d register the inputs every cycle.
  - start_edge = start & ~start_d; stop_edge = stop & ~stop_d.
- During reset, start_d and stop_d load the current inputs, so a level held high through reset is not an edge.
- States: IDLE, COUNTING.
- IDLE:
  - start_edge and stop_edge on the same edge: measurement <= 0, valid pulse, stay IDLE.
  - start_edge alone: counter <= 1, go to COUNTING.
  - stop_edge alone: ignored.
- COUNTING:
  - stop_edge: measurement <= counter, valid pulse, go to IDLE.
  - Else if counter == TIMEOUT_CYCLES: timeout pulse, go to IDLE.
  - Else: counter <= counter + 1.
  - start_edge while COUNTING: ignored. It does not restart the count.
- A start_edge on the same edge as the COUNTING->IDLE transition is ignored.
- Window accumulation, on each edge where measurement_valid is high:
  - sum (COUNTER_WIDTH+LOG2_AVERAGE bits) += measurement; running min and max are updated; sample count increments.
  - When this is the 2^LOG2_AVERAGE-th sample:
    - average <= (sum + measurement) >> LOG2_AVERAGE, truncated.
    - minimum and maximum are loaded from the final min/max, including this sample.
    - average_valid pulses.
    - sum, count and max clear to 0; internal min clears to all ones.
- Timeouts neither contribute to nor clear the window.
- Reset:
  - State goes to IDLE; all outputs go to 0.
  - Counter, sum and count clear; internal min clears to all ones.
  - Any in-flight measurement is abandoned with no pulse.

## Timing
- Counter value n at the edge where stop_edge is seen equals the number of edges since the start_edge edge.
- measurement_valid is visible in the cycle after that edge.
- Maximum reported measurement is TIMEOUT_CYCLES.
- timeout is visible in the cycle after edge start+TIMEOUT_CYCLES when no stop_edge arrives by then.
- busy is registered: high from the cycle after the start_edge edge through the cycle in which stop/timeout is sampled.
- average_valid is visible exactly one cycle after the final sample's measurement_valid.
- All pulses are exactly one cycle wide. measurement_valid, timeout and average_valid never coincide, except average_valid following the last measurement_valid.

## Test plan
Parameters for all scenarios: COUNTER_WIDTH=8, TIMEOUT_CYCLES=20, LOG2_AVERAGE=2.
- start rises at edge 10, stop rises at edge 15 -> measurement=5, one measurement_valid pulse; busy high 5 cycles; no timeout.
- start and stop rise on the same edge from IDLE -> measurement=0 with valid pulse; busy never asserts.
- Four measurements 3, 5, 6, 10 -> average=6, minimum=3, maximum=10; average_valid one cycle after the 4th valid. A fifth measurement 7 leaves the window outputs unchanged.
- start rises, no stop -> timeout pulse after 20 edges, busy drops; a later stop edge is ignored; the window count is unchanged, so the next 4 valid measurements complete a window.
- stop exactly 20 edges after start -> measurement=20, no timeout. A second start edge at +4 during the count does not restart the count.
- reset asserted at +3 with start held high, released at +6 -> no valid or timeout pulse, all outputs 0. The held-high start produces no measurement until it falls and rises again.
